// File: rtl/bpred_pkg.sv
// Shared types and constants for the branch-predictor update path.
//   BHT_SIZE_DEFAULT : default number of predictor table entries
//   WEAK_TAKEN       : counter value written to every entry during the init sweep
//   bpred_state_t    : controller FSM states (INIT sweep, RUN)
//   bpred_upd_t      : one buffered branch resolution {pc, taken}
package bpred_pkg;

  localparam int         BHT_SIZE_DEFAULT = 256;
  localparam logic [1:0] WEAK_TAKEN       = 2'b10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpred_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } bpred_upd_t;

endpackage

// File: rtl/bpred_update_fifo.sv
// Synchronous FIFO with flush, buffering resolved branches until the
// predictor consumes them.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : empty the FIFO next cycle; a same-cycle push is dropped
//   push, wdata  : enqueue (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   rdata        : head entry (valid when !empty)
//   full, empty  : occupancy flags
module bpred_update_fifo
  import bpred_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  bpred_upd_t wdata,
  input  logic       pop,
  output bpred_upd_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  bpred_upd_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: rdata is only looked at when !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Branch-predictor update controller. After reset it sweeps the whole
// predictor table to WEAK_TAKEN (INIT), then (RUN) buffers resolved branches
// from EX and presents them to the predictor in order with valid/ready.
//   clk, reset                  : clock, synchronous active-high reset
//   ex_valid/ex_pc/ex_taken     : resolved branch from EX, ex_ready = accepted
//   flush                       : drop all queued, not-yet-issued updates
//   upd_valid/upd_pc/upd_taken  : update to predictor, upd_ready = consumed
//   init_we/init_index/init_value : table initialisation write port
//   busy                        : high during the init sweep
module bpred_update_ctrl
  import bpred_pkg::*;
#(
  parameter int BHT_SIZE   = BHT_SIZE_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ex_valid,
  input  logic [31:0]                 ex_pc,
  input  logic                        ex_taken,
  output logic                        ex_ready,
  input  logic                        flush,
  output logic                        upd_valid,
  output logic [31:0]                 upd_pc,
  output logic                        upd_taken,
  input  logic                        upd_ready,
  output logic                        init_we,
  output logic [$clog2(BHT_SIZE)-1:0] init_index,
  output logic [1:0]                  init_value,
  output logic                        busy
);

  localparam int IW = $clog2(BHT_SIZE);

  bpred_state_t state;
  bpred_upd_t   wdata, head;
  logic         full, empty, run, push, pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      init_index <= '0;
    end else begin
      case (state)
        INIT: begin
          if (init_index == IW'(BHT_SIZE - 1)) begin
            state      <= RUN;
            init_index <= '0;
          end else begin
            init_index <= init_index + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign run        = (state == RUN);
  assign busy       = !run;
  assign init_we    = !run;
  assign init_value = WEAK_TAKEN;

  // ex_ready deliberately ignores a same-cycle pop: no pass-through when full.
  assign ex_ready  = run && !full;
  assign upd_valid = run && !empty;
  assign push      = ex_valid && ex_ready;
  assign pop       = upd_valid && upd_ready;

  assign wdata.pc    = ex_pc;
  assign wdata.taken = ex_taken;

  // Outputs read as zero whenever nothing is presented.
  assign upd_pc    = upd_valid ? head.pc    : '0;
  assign upd_taken = upd_valid ? head.taken : 1'b0;

  bpred_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Directed bench for bpred_update_ctrl: init sweep, in-order issue,
// backpressure/full, full with pop, flush, reset mid-run.
module tb_bpred_update_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic        ex_ready;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        init_we;
  logic [7:0]  init_index;
  logic [1:0]  init_value;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bpred_update_ctrl #(
    .BHT_SIZE   (256),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_taken   (ex_taken),
    .ex_ready   (ex_ready),
    .flush      (flush),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .init_we    (init_we),
    .init_index (init_index),
    .init_value (init_value),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed/outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk);
    ex_valid = 1'b1;
    ex_pc    = pc;
    ex_taken = tk;
  endtask

  task automatic chk_upd(input string tag, input logic [31:0] pc, input logic tk);
    chk({tag, ".vld"}, 32'(upd_valid), 32'd1);
    chk({tag, ".pc"},  upd_pc, pc);
    chk({tag, ".tk"},  32'(upd_taken), 32'(tk));
  endtask

  task automatic sweep();
    for (int i = 0; i < 256; i++) tick();
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    flush = 1'b0; upd_ready = 1'b0;
    #1;
    tick();
    reset = 1'b0;

    // ---- reset state and init sweep ----
    chk("rst.busy",   32'(busy),       32'd1);
    chk("rst.we",     32'(init_we),    32'd1);
    chk("rst.exrdy",  32'(ex_ready),   32'd0);
    chk("rst.updvld", 32'(upd_valid),  32'd0);
    chk("rst.updpc",  upd_pc,          32'd0);
    chk("rst.updtk",  32'(upd_taken),  32'd0);
    chk("rst.ival",   32'(init_value), 32'd2);
    for (int i = 0; i < 256; i++) begin
      chk("sweep.we",  32'(init_we),    32'd1);
      chk("sweep.idx", 32'(init_index), 32'(i));
      if (i == 128) begin
        ex_valid = 1'b1;
        chk("sweep.exrdy", 32'(ex_ready), 32'd0);
      end
      if (i == 200) chk("sweep.busy", 32'(busy), 32'd1);
      tick();
      ex_valid = 1'b0;
    end
    chk("run.busy",  32'(busy),      32'd0);
    chk("run.we",    32'(init_we),   32'd0);
    chk("run.exrdy", 32'(ex_ready),  32'd1);
    chk("run.empty", 32'(upd_valid), 32'd0);

    // ---- back-to-back in-order issue ----
    upd_ready = 1'b1;
    push(32'h100, 1'b1);
    chk("b2b.n0", 32'(upd_valid), 32'd0);
    tick();
    push(32'h104, 1'b0);
    chk_upd("b2b.n1", 32'h100, 1'b1);
    tick();
    push(32'h108, 1'b1);
    chk_upd("b2b.n2", 32'h104, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk_upd("b2b.n3", 32'h108, 1'b1);
    tick();
    chk("b2b.done", 32'(upd_valid), 32'd0);

    // ---- full / backpressure ----
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(32'h300 + 32'(4*i), (i % 2) == 0);
      chk("full.exrdy", 32'(ex_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    ex_valid = 1'b0;
    chk("full.exrdy0", 32'(ex_ready), 32'd0);
    chk_upd("full.hold0", 32'h300, 1'b1);
    tick();
    chk_upd("full.hold1", 32'h300, 1'b1);
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_upd("full.drain", 32'h300 + 32'(4*i), (i % 2) == 0);
      tick();
    end
    chk("full.no5th", 32'(upd_valid), 32'd0);

    // ---- full with simultaneous pop ----
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h400 + 32'(4*i), 1'b0);
      tick();
    end
    upd_ready = 1'b1;
    push(32'h500, 1'b1);
    chk("fpop.exrdy", 32'(ex_ready), 32'd0);
    chk_upd("fpop.head", 32'h400, 1'b0);
    tick();
    ex_valid = 1'b0;
    upd_ready = 1'b0;
    chk("fpop.occ3", 32'(ex_ready), 32'd1);
    chk_upd("fpop.next", 32'h404, 1'b0);
    upd_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk_upd("fpop.drain", 32'h400 + 32'(4*i), 1'b0);
      tick();
    end
    chk("fpop.no500", 32'(upd_valid), 32'd0);

    // ---- flush ----
    upd_ready = 1'b0;
    push(32'h600, 1'b1); tick();
    push(32'h604, 1'b1); tick();
    push(32'h608, 1'b1); tick();
    push(32'h200, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex_valid = 1'b0;
    upd_ready = 1'b1;
    chk("flush.vld0", 32'(upd_valid), 32'd0);
    chk("flush.exrdy", 32'(ex_ready), 32'd1);
    tick();
    chk("flush.vld1", 32'(upd_valid), 32'd0);
    push(32'h700, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk_upd("flush.after", 32'h700, 1'b0);
    tick();
    chk("flush.empty", 32'(upd_valid), 32'd0);

    // ---- reset mid-run ----
    upd_ready = 1'b0;
    push(32'h800, 1'b1); tick();
    push(32'h804, 1'b0); tick();
    ex_valid = 1'b0;
    chk("mrst.q", 32'(upd_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst.vld",   32'(upd_valid),  32'd0);
    chk("mrst.idx",   32'(init_index), 32'd0);
    chk("mrst.busy",  32'(busy),       32'd1);
    chk("mrst.exrdy", 32'(ex_ready),   32'd0);
    tick(); tick(); tick();
    chk("mrst.idx3",  32'(init_index), 32'd3);
    for (int i = 3; i < 256; i++) tick();
    chk("mrst.run",   32'(busy),      32'd0);
    chk("mrst.drop",  32'(upd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
